// File: rtl/axis_frame_source_pkg.sv
// Shared definitions for the AXI4-Stream frame source.
// Holds the pattern mode encodings, the LFSR mask, the FSM encoding and the LFSR step.
package axis_frame_source_pkg;

  localparam logic [1:0] MODE_INCR  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_WALK  = 2'd3;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Galois step; an all-zero state would lock up, so it is treated as 1
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] v;
    v = (s == 32'd0) ? 32'd1 : s;
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/axis_frame_source_pattern_step.sv
// Combinational next-value function for the stream data pattern.
// The owning module holds the pattern register.
module axis_pattern_step
  import axis_frame_source_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] nxt
);

  // Select the successor of the current pattern value for the active mode
  always_comb begin
    nxt = cur;
    case (mode)
      MODE_INCR:  nxt = cur + DATA_W'(1);
      MODE_CONST: nxt = cur;
      MODE_LFSR: begin
        nxt       = {DATA_W{1'b0}};
        nxt[31:0] = lfsr_step(cur[31:0]);
      end
      MODE_WALK:  nxt = {cur[DATA_W-2:0], cur[DATA_W-1]};
      default:    nxt = cur;
    endcase
  end

endmodule

// File: rtl/axis_frame_source.sv
// Packet generator for the DMA S2MM channel: cfg_pkts packets of cfg_len beats,
// cfg_gap idle cycles between them, data from a selectable test pattern.
module axis_frame_source
  import axis_frame_source_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [7:0]            cfg_pkts,
  input  logic [GAP_W-1:0]      cfg_gap,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_W-1:0]     cfg_seed,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  cfg_err,
  output logic [7:0]            pkt_cnt
);

  localparam int KEEP_W = DATA_W / 8;

  logic [1:0]          state, state_d;
  logic [LEN_W-1:0]    len_q, len_d, beat_cnt, beat_cnt_d;
  logic [7:0]          pkts_q, pkts_d, pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d, gap_cnt, gap_cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   pattern, pattern_d, pattern_nxt;
  logic                abort_seen, abort_seen_d;
  logic                tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                done_d, aborted_d, cfg_err_d;
  logic                busy_q, done_q, aborted_q, cfg_err_q;
  logic [KEEP_W-1:0]   tkeep_q;
  logic                hs;

  axis_pattern_step #(.DATA_W(DATA_W)) u_step (
    .cur  (pattern),
    .mode (mode_q),
    .nxt  (pattern_nxt)
  );

  assign hs = tvalid_q & m_axis_tready;

  // Next-state logic; tlast is precomputed for the beat about to be presented
  always_comb begin
    state_d      = state;
    len_d        = len_q;
    pkts_d       = pkts_q;
    gap_d        = gap_q;
    mode_d       = mode_q;
    beat_cnt_d   = beat_cnt;
    gap_cnt_d    = gap_cnt;
    pkt_cnt_d    = pkt_cnt_q;
    pattern_d    = pattern;
    abort_seen_d = abort_seen;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    cfg_err_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if ((cfg_len == {LEN_W{1'b0}}) || (cfg_pkts == 8'd0)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d      = ST_SEND;
            len_d        = cfg_len;
            pkts_d       = cfg_pkts;
            gap_d        = cfg_gap;
            mode_d       = cfg_mode;
            pkt_cnt_d    = 8'd0;
            beat_cnt_d   = {LEN_W{1'b0}};
            abort_seen_d = 1'b0;
            pattern_d    = (cfg_mode == MODE_WALK) ? DATA_W'(1) : cfg_seed;
            tvalid_d     = 1'b1;
            tlast_d      = (cfg_len == LEN_W'(1));
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        abort_seen_d = abort_seen | abort;
        if (hs) begin
          pattern_d = pattern_nxt;
          if (tlast_q) begin
            pkt_cnt_d    = pkt_cnt_q + 8'd1;
            beat_cnt_d   = {LEN_W{1'b0}};
            abort_seen_d = 1'b0;
            if (abort_seen | abort) begin
              state_d   = ST_IDLE;
              aborted_d = 1'b1;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
            end else if ((pkt_cnt_q + 8'd1) == pkts_q) begin
              state_d  = ST_IDLE;
              done_d   = 1'b1;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
            end else if (gap_q != {GAP_W{1'b0}}) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
            end else begin
              tlast_d = (len_q == LEN_W'(1));
            end
          end else begin
            beat_cnt_d = beat_cnt + LEN_W'(1);
            tlast_d    = ((beat_cnt + LEN_W'(1)) == (len_q - LEN_W'(1)));
          end
        end else begin
          pattern_d = pattern;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_d  = ST_SEND;
          tvalid_d = 1'b1;
          tlast_d  = (len_q == LEN_W'(1));
        end else begin
          gap_cnt_d = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      len_q      <= {LEN_W{1'b0}};
      pkts_q     <= 8'd0;
      gap_q      <= {GAP_W{1'b0}};
      mode_q     <= 2'd0;
      beat_cnt   <= {LEN_W{1'b0}};
      gap_cnt    <= {GAP_W{1'b0}};
      pkt_cnt_q  <= 8'd0;
      pattern    <= {DATA_W{1'b0}};
      abort_seen <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tkeep_q    <= {KEEP_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state      <= state_d;
      len_q      <= len_d;
      pkts_q     <= pkts_d;
      gap_q      <= gap_d;
      mode_q     <= mode_d;
      beat_cnt   <= beat_cnt_d;
      gap_cnt    <= gap_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pattern    <= pattern_d;
      abort_seen <= abort_seen_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tkeep_q    <= {KEEP_W{tvalid_d}};
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign m_axis_tdata  = pattern;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign cfg_err       = cfg_err_q;
  assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed self-checking bench for axis_frame_source.
// Inputs are driven 1 ns after the rising edge; outputs are sampled 4 ns after it.
module tb_axis_frame_source;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int GAP_W  = 8;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [7:0]        cfg_pkts = '0;
  logic [GAP_W-1:0]  cfg_gap = '0;
  logic [1:0]        cfg_mode = '0;
  logic [DATA_W-1:0] cfg_seed = '0;
  logic [DATA_W-1:0] tdata;
  logic [3:0]        tkeep;
  logic              tvalid;
  logic              tready = 1'b0;
  logic              tlast;
  logic              busy, done, aborted, cfg_err;
  logic [7:0]        pkt_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] beats[$];
  bit          lasts[$];
  bit          vhist[$];
  int          last_i, end_i;
  bit          end_done, end_abort;

  always #5 aclk = ~aclk;

  axis_frame_source #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_pkts(cfg_pkts), .cfg_gap(cfg_gap),
    .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast),
    .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err),
    .pkt_cnt(pkt_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] model_lfsr(input logic [31:0] s);
    logic [31:0] v;
    v = (s == 32'd0) ? 32'd1 : s;
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  task automatic launch(input int len, input int pkts, input int gap, input int mode,
                        input logic [31:0] seed);
    cfg_len  = LEN_W'(len);
    cfg_pkts = 8'(pkts);
    cfg_gap  = GAP_W'(gap);
    cfg_mode = 2'(mode);
    cfg_seed = seed;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Record handshakes until done/aborted or the cycle budget runs out
  task automatic collect(input int budget, input bit rnd, input int abort_at);
    logic [31:0] prev_d;
    bit          prev_l;
    bit          prev_stall;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    beats.delete(); lasts.delete(); vhist.delete();
    end_done = 1'b0; end_abort = 1'b0; last_i = -1; end_i = -1;
    for (int i = 0; i < budget; i++) begin
      if (done || aborted) begin
        end_done  = done;
        end_abort = aborted;
        end_i     = i;
        break;
      end
      if (rnd) tready = ($urandom_range(0, 1) == 1);
      if (abort_at >= 0 && beats.size() == abort_at) abort = 1'b1;
      #3;
      if (prev_stall) begin
        check("stall_valid", tvalid, 1);
        check("stall_data", tdata, prev_d);
        check("stall_last", tlast, prev_l);
      end
      check("tkeep", tkeep, tvalid ? 4'hF : 4'h0);
      vhist.push_back(tvalid);
      if (tvalid && tready) begin
        beats.push_back(tdata);
        lasts.push_back(tlast);
        if (tlast) last_i = i;
      end
      prev_stall = tvalid && !tready;
      prev_d     = tdata;
      prev_l     = tlast;
      tick();
    end
    if (end_i < 0) check("timeout", 0, 1);
  endtask

  initial begin
    logic [31:0] exp_d;
    int nlast;
    bit exp_v2[8];
    exp_v2 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    #2;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // 1: single packet, incrementing from 0x10
    tready = 1'b1;
    launch(4, 1, 0, 0, 32'h10);
    collect(40, 1'b0, -1);
    check("t1_latency", vhist[0], 1);
    check("t1_nbeats", beats.size(), 4);
    for (int k = 0; k < 4 && k < beats.size(); k++) begin
      check("t1_data", beats[k], 32'h10 + k);
      check("t1_last", lasts[k], (k == 3));
    end
    check("t1_done", end_done, 1);
    check("t1_done_delay", end_i - last_i, 1);
    check("t1_pkt_cnt", pkt_cnt, 1);
    tick();
    check("t1_done_pulse", done, 0);

    // 2: two packets with a 2-cycle gap
    launch(3, 2, 2, 0, 32'h0);
    collect(60, 1'b0, -1);
    check("t2_nbeats", beats.size(), 6);
    for (int k = 0; k < 6 && k < beats.size(); k++) check("t2_data", beats[k], k);
    check("t2_vhist_len", vhist.size(), 8);
    for (int k = 0; k < 8 && k < vhist.size(); k++) check("t2_vhist", vhist[k], exp_v2[k]);
    check("t2_done", end_done, 1);
    check("t2_pkt_cnt", pkt_cnt, 2);

    // 3: LFSR with random back-pressure
    launch(8, 1, 0, 2, 32'h1);
    collect(400, 1'b1, -1);
    check("t3_nbeats", beats.size(), 8);
    exp_d = 32'h1;
    nlast = 0;
    for (int k = 0; k < beats.size(); k++) begin
      check("t3_data", beats[k], exp_d);
      exp_d = model_lfsr(exp_d);
      if (lasts[k]) nlast++;
    end
    check("t3_one_tlast", nlast, 1);
    if (beats.size() == 8) check("t3_last_pos", lasts[7], 1);
    check("t3_done", end_done, 1);

    // 4: abort during the first packet completes that packet only
    tready = 1'b1;
    launch(5, 4, 1, 0, 32'h100);
    collect(80, 1'b0, 2);
    check("t4_nbeats", beats.size(), 5);
    if (beats.size() == 5) check("t4_last", lasts[4], 1);
    check("t4_aborted", end_abort, 1);
    check("t4_not_done", end_done, 0);
    check("t4_pkt_cnt", pkt_cnt, 1);
    for (int k = 0; k < 3; k++) begin
      #3;
      check("t4_idle_tvalid", tvalid, 0);
      check("t4_idle_busy", busy, 0);
      tick();
    end
    abort = 1'b0;

    // 5: illegal configurations, then start while busy
    launch(0, 1, 0, 0, 32'h5);
    check("t5_err_len", cfg_err, 1);
    check("t5_err_tvalid", tvalid, 0);
    check("t5_err_pkt_cnt", pkt_cnt, 1);
    tick();
    check("t5_err_pulse", cfg_err, 0);
    launch(3, 0, 0, 0, 32'h5);
    check("t5_err_pkts", cfg_err, 1);
    check("t5_err_busy", busy, 0);
    tready = 1'b0;
    launch(4, 1, 0, 0, 32'hAA);
    check("t5_run_tvalid", tvalid, 1);
    check("t5_run_tdata", tdata, 32'hAA);
    tick();
    launch(2, 1, 0, 1, 32'h55);
    check("t5_busy_tdata", tdata, 32'hAA);
    check("t5_busy_err", cfg_err, 0);
    check("t5_busy", busy, 1);

    // 6: asynchronous reset mid-packet, then walking one
    aresetn = 1'b0;
    #1;
    check("t6_rst_tvalid", tvalid, 0);
    check("t6_rst_tdata", tdata, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pkt_cnt", pkt_cnt, 0);
    tick();
    aresetn = 1'b1;
    tick();
    tready = 1'b1;
    launch(4, 1, 0, 3, 32'hDEAD);
    collect(40, 1'b0, -1);
    check("t6_nbeats", beats.size(), 4);
    for (int k = 0; k < 4 && k < beats.size(); k++) check("t6_walk", beats[k], 32'h1 << k);
    check("t6_done", end_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
